// File: rtl/mips_muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and FSM states.
package mips_muldiv_unit_pkg;

   localparam logic [1:0] MdMult  = 2'b00;
   localparam logic [1:0] MdMultu = 2'b01;
   localparam logic [1:0] MdDiv   = 2'b10;
   localparam logic [1:0] MdDivu  = 2'b11;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StFix  = 2'b10
   } state_e;

endpackage

// File: rtl/mips_muldiv_unit_iter.sv
// One combinational iteration: shift-add (multiply) or restoring shift-subtract (divide).
module mips_muldiv_unit_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] opnd_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] opnd_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;

   always_comb begin
      sum     = {1'b0, acc_i} + (opnd_i[0] ? {1'b0, m_i} : '0);
      shifted = {acc_i, opnd_i[WIDTH-1]};
      acc_o   = acc_i;
      opnd_o  = opnd_i;
      if (is_div_i) begin
         // Partial remainder stays below the divisor, so it always fits WIDTH bits.
         if (shifted >= {1'b0, m_i}) begin
            acc_o  = WIDTH'(shifted - {1'b0, m_i});
            opnd_o = {opnd_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o  = shifted[WIDTH-1:0];
            opnd_o = {opnd_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_o  = sum[WIDTH:1];
         opnd_o = {sum[0], opnd_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO moves.
module mips_muldiv_unit
   import mips_muldiv_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] WriteData,
   input  logic             mthi,
   input  logic             mtlo,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              is_div_q, is_div_d;
   logic              sa_q, sa_d, sb_q, sb_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]  acc_q, acc_d, opnd_q, opnd_d;
   logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
   logic              done_q, done_d;

   logic [WIDTH-1:0]   iter_acc, iter_opnd;
   logic               op_signed, op_div;
   logic [WIDTH-1:0]   a_mag, b_mag, a_raw;
   logic [2*WIDTH-1:0] prod;

   mips_muldiv_unit_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .m_i      (is_div_q ? b_q : a_q),
      .acc_o    (iter_acc),
      .opnd_o   (iter_opnd)
   );

   always_comb begin
      op_signed = (op == MdMult) || (op == MdDiv);
      op_div    = (op == MdDiv) || (op == MdDivu);
      a_mag     = (op_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
      b_mag     = (op_signed && WriteData[WIDTH-1]) ? -WriteData : WriteData;
      // Sign bits are only ever set for signed ops, so this recovers the raw dividend.
      a_raw     = sa_q ? -a_q : a_q;
      prod      = (sa_q ^ sb_q) ? -{acc_q, opnd_q} : {acc_q, opnd_q};

      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               is_div_d = op_div;
               sa_d     = op_signed & SrcA[WIDTH-1];
               sb_d     = op_signed & WriteData[WIDTH-1];
               a_d      = a_mag;
               b_d      = b_mag;
               acc_d    = '0;
               opnd_d   = op_div ? a_mag : b_mag;
               cnt_d    = CntW'(WIDTH - 1);
               state_d  = StRun;
            end else begin
               if (mthi) hi_d = SrcA;
               if (mtlo) lo_d = SrcA;
            end
         end
         StRun: begin
            acc_d  = iter_acc;
            opnd_d = iter_opnd;
            if (cnt_q == '0) state_d = StFix;
            else             cnt_d   = cnt_q - 1'b1;
         end
         StFix: begin
            if (!is_div_q) begin
               {hi_d, lo_d} = prod;
            end else if (b_q == '0) begin
               lo_d = '1;
               hi_d = a_raw;
            end else begin
               lo_d = (sa_q ^ sb_q) ? -opnd_q : opnd_q;
               hi_d = sa_q ? -acc_q : acc_q;
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
